// File: rtl/hazd_sb.sv
// ID-stage hazard unit: one-hot operand-forward selection for NUM_SRC sources plus a
// per-register load-use scoreboard that stalls ID and counts stall cycles.
module hazd_sb #(
   parameter int AW       = 4,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 2,
   parameter int CNTW     = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_SRC*AW-1:0]  D_RS,
   input  logic [NUM_SRC-1:0]     D_VALID_S,
   input  logic                   D_ISSUE,
   input  logic                   D_WE,
   input  logic                   D_LOAD,
   input  logic [AW-1:0]          D_RD,
   input  logic [AW-1:0]          E_RA1,
   input  logic [AW-1:0]          E_RA2,
   input  logic                   E_VALID1,
   input  logic                   E_VALID2,
   input  logic [AW-1:0]          M_RA,
   input  logic                   M_VALID,
   input  logic                   FLUSH,
   output logic                   STALL,
   output logic [NUM_SRC-1:0]     FWD_REQ_M,
   output logic [NUM_SRC*4-1:0]   FWD_SEL,
   output logic [(2**AW)-1:0]     SB_BUSY,
   output logic [CNTW-1:0]        STALL_CNT
);

   localparam int NREG = 2**AW;
   localparam int CW   = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(LOAD_LAT);

   logic [CW-1:0] cnt [NREG];
   logic          accept;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   // Forwarding: priority E1 > E2 > MEM > register file, MEM request unmasked
   always_comb begin
      logic [AW-1:0] x;
      logic          he1, he2, hm;
      FWD_SEL   = '0;
      FWD_REQ_M = '0;
      x         = '0;
      he1       = 1'b0;
      he2       = 1'b0;
      hm        = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         x   = D_RS[s*AW +: AW];
         he1 = (x == E_RA1) && D_VALID_S[s] && E_VALID1;
         he2 = (x == E_RA2) && D_VALID_S[s] && E_VALID2;
         hm  = (x == M_RA)  && D_VALID_S[s] && M_VALID;
         FWD_SEL[s*4 +: 4] = {~he1 & ~he2 & ~hm, ~he1 & ~he2 & hm, ~he1 & he2, he1};
         FWD_REQ_M[s]      = hm;
      end
   end

   always_comb begin
      STALL = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (D_VALID_S[s] && (cnt[D_RS[s*AW +: AW]] != '0))
            STALL = 1'b1;
      end
   end

   always_comb begin
      SB_BUSY = '0;
      for (int r = 0; r < NREG; r++)
         SB_BUSY[r] = (cnt[r] != '0);
   end

   assign accept = D_ISSUE & ~STALL & ~FLUSH;

   // Scoreboard: a newly accepted writer always overrides an older pending load
   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         for (int r = 0; r < NREG; r++)
            cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (accept && D_WE && (D_RD == AW'(r)))
               cnt[r] <= D_LOAD ? LAT_C : '0;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - CW'(1);
         end
      end
   end

   // Stall-cycle counter ignores FLUSH and saturates instead of wrapping
   always_ff @(posedge CLK) begin
      if (RST)
         STALL_CNT <= '0;
      else if (STALL)
         STALL_CNT <= sat_inc(STALL_CNT);
   end

endmodule

// File: tb/tb_hazd_sb.sv
// Directed bench for hazd_sb: forwarding priority, load-use stall window, WAW override,
// blocked issue, flush/reset and saturating stall counter.
module tb_hazd_sb;

   localparam int AW       = 4;
   localparam int NUM_SRC  = 2;
   localparam int LOAD_LAT = 2;
   localparam int CNTW     = 4;
   localparam int NREG     = 2**AW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_SRC*AW-1:0] d_rs;
   logic [NUM_SRC-1:0]    d_valid_s;
   logic                  d_issue, d_we, d_load;
   logic [AW-1:0]         d_rd, e_ra1, e_ra2, m_ra;
   logic                  e_valid1, e_valid2, m_valid, flush;
   logic                  stall;
   logic [NUM_SRC-1:0]    fwd_req_m;
   logic [NUM_SRC*4-1:0]  fwd_sel;
   logic [NREG-1:0]       sb_busy;
   logic [CNTW-1:0]       stall_cnt;

   int tests = 0;
   int fails = 0;

   hazd_sb #(.AW(AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT), .CNTW(CNTW)) dut (
      .CLK(clk), .RST(rst), .D_RS(d_rs), .D_VALID_S(d_valid_s), .D_ISSUE(d_issue),
      .D_WE(d_we), .D_LOAD(d_load), .D_RD(d_rd), .E_RA1(e_ra1), .E_RA2(e_ra2),
      .E_VALID1(e_valid1), .E_VALID2(e_valid2), .M_RA(m_ra), .M_VALID(m_valid),
      .FLUSH(flush), .STALL(stall), .FWD_REQ_M(fwd_req_m), .FWD_SEL(fwd_sel),
      .SB_BUSY(sb_busy), .STALL_CNT(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; flush = 1'b0;
      d_rs = '0; d_valid_s = '0; d_issue = 1'b0; d_we = 1'b0; d_load = 1'b0; d_rd = '0;
      e_ra1 = '0; e_ra2 = '0; m_ra = '0; e_valid1 = 1'b0; e_valid2 = 1'b0; m_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic issue_load(input logic [AW-1:0] rd);
      d_issue = 1'b1; d_we = 1'b1; d_load = 1'b1; d_rd = rd;
   endtask

   task automatic test_reset();
      idle();
      d_rs = {4'd2, 4'd1}; d_valid_s = 2'b11;
      issue_load(4'd1);
      rst = 1'b1;
      tick();
      tests++;
      if (sb_busy !== '0) begin fails++; $display("FAIL reset_busy got %h exp 0", sb_busy); end
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
      tests++;
      if (stall_cnt !== '0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_fwd_priority();
      do_reset();
      d_rs = {4'd0, 4'd5}; d_valid_s = 2'b01;
      e_ra1 = 4'd5; e_ra2 = 4'd5; m_ra = 4'd5;
      e_valid1 = 1'b1; e_valid2 = 1'b1; m_valid = 1'b1;
      #1;
      tests++;
      if (fwd_sel !== 8'b1000_0001 || fwd_req_m !== 2'b01) begin
         fails++; $display("FAIL fwd_e1 got sel=%b req=%b exp 10000001/01", fwd_sel, fwd_req_m);
      end
      e_valid1 = 1'b0; #1;
      tests++;
      if (fwd_sel !== 8'b1000_0010 || fwd_req_m !== 2'b01) begin
         fails++; $display("FAIL fwd_e2 got sel=%b req=%b exp 10000010/01", fwd_sel, fwd_req_m);
      end
      e_valid2 = 1'b0; #1;
      tests++;
      if (fwd_sel !== 8'b1000_0100 || fwd_req_m !== 2'b01) begin
         fails++; $display("FAIL fwd_m got sel=%b req=%b exp 10000100/01", fwd_sel, fwd_req_m);
      end
      m_valid = 1'b0; #1;
      tests++;
      if (fwd_sel !== 8'b1000_1000 || fwd_req_m !== 2'b00) begin
         fails++; $display("FAIL fwd_rf got sel=%b req=%b exp 10001000/00", fwd_sel, fwd_req_m);
      end
      // Source 1 valid: E1 matches src0 only, E2 and MEM match src1
      d_rs = {4'd9, 4'd5}; d_valid_s = 2'b11;
      e_ra1 = 4'd5; e_valid1 = 1'b1; e_ra2 = 4'd9; e_valid2 = 1'b1; m_ra = 4'd9; m_valid = 1'b1;
      #1;
      tests++;
      if (fwd_sel !== 8'b0010_0001 || fwd_req_m !== 2'b10) begin
         fails++; $display("FAIL fwd_src1 got sel=%b req=%b exp 00100001/10", fwd_sel, fwd_req_m);
      end
      idle();
   endtask

   task automatic test_load_use();
      do_reset();
      issue_load(4'd3);
      tick();
      d_we = 1'b0; d_load = 1'b0; d_rd = '0;
      d_rs = {4'd0, 4'd3}; d_valid_s = 2'b01;
      #1;
      tests++;
      if (stall !== 1'b1 || sb_busy !== 16'h0008) begin
         fails++; $display("FAIL lu_cyc1 got stall=%b busy=%h exp 1/0008", stall, sb_busy);
      end
      tick();
      tests++;
      if (stall !== 1'b1 || sb_busy !== 16'h0008) begin
         fails++; $display("FAIL lu_cyc2 got stall=%b busy=%h exp 1/0008", stall, sb_busy);
      end
      tick();
      tests++;
      if (stall !== 1'b0 || sb_busy !== 16'h0000) begin
         fails++; $display("FAIL lu_cyc3 got stall=%b busy=%h exp 0/0000", stall, sb_busy);
      end
      tests++;
      if (stall_cnt !== 4'd2) begin fails++; $display("FAIL lu_cnt got %0d exp 2", stall_cnt); end
      idle();
      tick();
      tests++;
      if (stall_cnt !== 4'd2) begin fails++; $display("FAIL lu_cnt_hold got %0d exp 2", stall_cnt); end
   endtask

   task automatic test_waw();
      do_reset();
      issue_load(4'd7);
      tick();
      d_load = 1'b0;
      #1;
      tests++;
      if (stall !== 1'b0 || sb_busy !== 16'h0080) begin
         fails++; $display("FAIL waw_pend got stall=%b busy=%h exp 0/0080", stall, sb_busy);
      end
      tick();
      idle();
      d_rs = {4'd0, 4'd7}; d_valid_s = 2'b01; d_issue = 1'b1;
      #1;
      tests++;
      if (stall !== 1'b0 || sb_busy !== 16'h0000) begin
         fails++; $display("FAIL waw_clear got stall=%b busy=%h exp 0/0000", stall, sb_busy);
      end
      d_issue = 1'b0;
      tick();
      tests++;
      if (stall !== 1'b0) begin fails++; $display("FAIL waw_reader got stall=%b exp 0", stall); end
      idle();
   endtask

   task automatic test_blocked_issue();
      do_reset();
      issue_load(4'd3);
      tick();
      d_rs = {4'd0, 4'd3}; d_valid_s = 2'b01;
      issue_load(4'd9);
      tick();
      tests++;
      if (sb_busy !== 16'h0008) begin
         fails++; $display("FAIL blk_busy1 got %h exp 0008", sb_busy);
      end
      tick();
      tests++;
      if (sb_busy !== 16'h0000 || stall !== 1'b0) begin
         fails++; $display("FAIL blk_busy2 got busy=%h stall=%b exp 0000/0", sb_busy, stall);
      end
      idle();
   endtask

   // Leaves loads to r1 and r2 pending with two stall cycles already counted
   task automatic setup_pending();
      do_reset();
      issue_load(4'd4);
      tick();
      d_rs = {4'd0, 4'd4}; d_valid_s = 2'b01;
      issue_load(4'd1);
      tick(); tick(); tick();
      d_valid_s = 2'b00;
      issue_load(4'd2);
      tick();
      idle();
   endtask

   task automatic test_flush();
      setup_pending();
      flush = 1'b1;
      #1;
      tests++;
      if (sb_busy !== 16'h0006 || stall_cnt !== 4'd2) begin
         fails++; $display("FAIL fl_pre got busy=%h cnt=%0d exp 0006/2", sb_busy, stall_cnt);
      end
      tick();
      flush = 1'b0;
      d_rs = {4'd2, 4'd1}; d_valid_s = 2'b11;
      #1;
      tests++;
      if (sb_busy !== 16'h0000 || stall !== 1'b0 || stall_cnt !== 4'd2) begin
         fails++;
         $display("FAIL fl_post got busy=%h stall=%b cnt=%0d exp 0000/0/2", sb_busy, stall, stall_cnt);
      end
      idle();
      setup_pending();
      d_rs = {4'd2, 4'd1}; d_valid_s = 2'b11;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      tests++;
      if (sb_busy !== 16'h0000 || stall !== 1'b0 || stall_cnt !== 4'd0) begin
         fails++;
         $display("FAIL rst_mid got busy=%h stall=%b cnt=%0d exp 0000/0/0", sb_busy, stall, stall_cnt);
      end
      idle();
   endtask

   task automatic test_saturation();
      do_reset();
      d_rs = {4'd0, 4'd3}; d_valid_s = 2'b01;
      issue_load(4'd3);
      for (int i = 0; i < 10; i++) tick();
      tests++;
      if (stall_cnt !== 4'd6) begin fails++; $display("FAIL sat_mid got %0d exp 6", stall_cnt); end
      for (int i = 0; i < 20; i++) tick();
      tests++;
      if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_top got %0d exp 15", stall_cnt); end
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
      idle();
   endtask

   initial begin
      idle();
      #2;
      test_reset();
      test_fwd_priority();
      test_load_use();
      test_waw();
      test_blocked_issue();
      test_flush();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
